mem_byte_master: RTL and testbench
==================================

# mem_byte_master

Bus initiator that turns 8/16/32-bit load/store requests from the core-side memory interface into sequences of single-byte accesses on a byte-wide synchronous-write / combinational-read memory port (one `en`/`we`/`adr` strobe per byte). It sits between the CPU load/store unit and the byte-wide data memory in `mem_if`. The master handles big-endian lane ordering, alignment/range checking and the response handshake.

## Interface
- `ADR_W`, 14: memory byte-address width (16 KB)
- `clk` input 1: the single clock; all state updates on rising edge
- `rst` input 1: asynchronous, active-high reset
- `req_valid` input 1: request present
- `req_ready` output 1: master can accept; high only in IDLE
- `req_we` input 1: 1 = store, 0 = load
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 illegal
- `req_adr` input 32: byte address
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0])
- `rsp_valid` output 1: one-cycle pulse, response valid
- `rsp_err` output 1: misaligned, illegal size or out of range; qualified by `rsp_valid`
- `rsp_rdata` output 32: load data, right-aligned, zero-extended; 0 for stores and errors
- `mem_adr` output ADR_W: memory byte address
- `mem_dat_o` output 8: write byte
- `mem_dat_i` input 8: read byte, combinational from memory, valid while `mem_en && !mem_we`
- `mem_we` output 1: write strobe
- `mem_en` output 1: access enable

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch `we`/`size`/`adr`/`wdata`, clear the beat counter and read shift register, then check the request.
- Request check, in priority order:
  - `size`=11 is an error.
  - Misaligned is an error: half needs `adr[0]`=0; word needs `adr[1:0]`=0.
  - Out of range is an error: `adr[31:ADR_W]` ≠ 0.
  - On error: IDLE→RESP with `rsp_err`=1 and no memory access.
  - Otherwise: IDLE→ACCESS.
- ACCESS
  - N beats: N = 1, 2 or 4 by size.
  - Beat k drives `mem_en`=1, `mem_we`=`we`, `mem_adr` = `adr[ADR_W-1:0]` + k.
  - Big-endian lane order: beat 0 carries the most-significant byte of the right-aligned datum.
    - Word writes send `wdata[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
    - Half writes send `wdata[15:8]`, `[7:0]`.
  - Loads: at each beat's rising edge, `rdata` = {`rdata[23:0]`, `mem_dat_i`}. Zero pre-clear gives zero extension.
  - After the last beat, go to RESP.
- RESP
  - `rsp_valid`=1 for exactly one cycle; `rsp_err` and `rsp_rdata` are driven from registers.
  - Then go to IDLE.
  - There is no response backpressure: the consumer must take the pulse.
- All memory-side outputs are registered or decoded from registered state. They are 0 outside ACCESS, so `mem_en`=0 in IDLE and RESP.
- Address increments never wrap, because aligned in-range accesses stay within the range.

## Timing
- Request accepted at edge T (`req_valid && req_ready`).
- Beats occupy cycles T+1 … T+N.
- `rsp_valid` is high in cycle T+N+1; `req_ready` is high again in cycle T+N+2.
- Latency per size:
  - Byte: 2 cycles to response, throughput 1 request per 3 cycles.
  - Half: 3 cycles.
  - Word: 5 cycles.
  - Error: `rsp_valid` in T+1, `req_ready` in T+2.
- Request inputs are ignored when `req_ready`=0, so back-to-back requests are not overlapped.
- Reset values, asynchronous:
  - State = IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mem_en`=0, `mem_we`=0, `mem_adr`=0, `mem_dat_o`=0.
- Reset mid-ACCESS:
  - `mem_en`/`mem_we` drop immediately and no response is issued.
  - Bytes already written stay in memory; the initiator must reissue.
- Reset asserted during RESP: the pulse is truncated and the response is lost.

## Structure
- Shared package `mem_if_pkg`:
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - State encoding for IDLE/ACCESS/RESP.
  - Function `beats(size)` returning N−1.
- Single flat module; no sub-module is warranted. The beat counter is 2 bits and the shift register is 32 bits, both inline.

## Test plan
- **Word store then load:** with the memory model attached, store `adr`=0x0100, `wdata`=0x11223344 → memory bytes [0x100..0x103] = 11,22,33,44. Load the same address → `rsp_rdata`=0x11223344, `rsp_err`=0, `rsp_valid` exactly 5 cycles after accept.
- **Half and byte:** store half 0xBEEF at 0x0202 → [0x202]=BE, [0x203]=EF. Load byte at 0x0203 → `rsp_rdata`=0x000000EF, latency 2.
- **Errors:** word at 0x0102, half at 0x0001, size=11, and word at 0x00004000 each give `rsp_err`=1 and `rsp_rdata`=0 one cycle after accept, with `mem_en` never asserted.
- **Top of range:** word load at 0x3FFC returns bytes 0x3FFC–0x3FFF in order, with no address wrap.
- **Back-to-back:** hold `req_valid` high with 3 word requests → `req_ready` pulses exactly once per 6 cycles and each response matches its own request.
- **Reset mid-store:** assert `rst` after beat 1 of a word store to 0x0300 → `mem_en` drops in the same cycle, no `rsp_valid`, only [0x300] is updated, and `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared encodings for the byte-wide memory initiator.
// Sizes, FSM states and the per-size beat count helper.
package mem_if_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Number of beats minus one for a legal size.
  function automatic logic [1:0] beats(input logic [1:0] size);
    unique case (size)
      SZ_HALF: beats = 2'd1;
      SZ_WORD: beats = 2'd3;
      default: beats = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_master_if.sv
// Core-side request/response and byte-wide memory port bundle.
// The master modport is the initiator's view.
interface mem_byte_master_if #(
  parameter int ADR_W = 14
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic [31:0]      req_adr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_err;
  logic [31:0]      rsp_rdata;
  logic [ADR_W-1:0] mem_adr;
  logic [7:0]       mem_dat_o;
  logic [7:0]       mem_dat_i;
  logic             mem_we;
  logic             mem_en;

  modport master (
    input  req_valid, req_we, req_size,
    input  req_adr, req_wdata, mem_dat_i,
    output req_ready, rsp_valid, rsp_err,
    output rsp_rdata, mem_adr, mem_dat_o,
    output mem_we, mem_en
  );

  modport slave (
    output req_valid, req_we, req_size,
    output req_adr, req_wdata, mem_dat_i,
    input  req_ready, rsp_valid, rsp_err,
    input  rsp_rdata, mem_adr, mem_dat_o,
    input  mem_we, mem_en
  );
endinterface

// File: rtl/mem_byte_master.sv
// Splits 8/16/32-bit loads/stores into big-endian byte beats
// on a byte-wide memory, with alignment and range checking.
module mem_byte_master
  import mem_if_pkg::*;
#(
  parameter int ADR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  mem_byte_master_if.master bus
);

  state_e           r_state;
  state_e           w_next;
  logic             r_we;
  logic [1:0]       r_size;
  logic [ADR_W-1:0] r_adr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [1:0]       r_cnt;
  logic             r_err;

  logic             w_err;
  logic             w_last;
  logic [1:0]       w_lane;
  logic             w_mis;
  logic             w_oor;

  always_comb begin
    w_mis = 1'b0;
    if (bus.req_size == SZ_HALF)
      w_mis = bus.req_adr[0];
    else if (bus.req_size == SZ_WORD)
      w_mis = |bus.req_adr[1:0];
    w_oor = |bus.req_adr[31:ADR_W];
    w_err = (bus.req_size == SZ_ILL)
          | w_mis | w_oor;
  end

  assign w_last = (r_cnt == beats(r_size));
  // Beat 0 carries the most-significant lane.
  assign w_lane = beats(r_size) - r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid)
          w_next = w_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_last)
          w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_size  <= bus.req_size;
            r_adr   <= bus.req_adr[ADR_W-1:0];
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_cnt   <= 2'd0;
            r_err   <= w_err;
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we)
            r_rdata <= {r_rdata[23:0], bus.mem_dat_i};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = r_err;
    bus.rsp_rdata = r_rdata;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_adr   = '0;
    bus.mem_dat_o = 8'h00;
    unique case (r_state)
      ST_IDLE: bus.req_ready = 1'b1;
      ST_ACCESS: begin
        bus.mem_en  = 1'b1;
        bus.mem_we  = r_we;
        bus.mem_adr = r_adr
                    + {{(ADR_W-2){1'b0}}, r_cnt};
        if (r_we)
          bus.mem_dat_o = r_wdata[{w_lane, 3'b000} +: 8];
      end
      ST_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_byte_master.sv
// Bench for mem_byte_master: byte memory model plus a
// request-level reference model, directed and random traffic.
module tb_mem_byte_master;

  localparam int ADR_W = 14;
  localparam int MSZ   = 1 << ADR_W;

  logic clk;
  logic rst;

  mem_byte_master_if #(.ADR_W(ADR_W)) bus ();

  mem_byte_master #(.ADR_W(ADR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem  [MSZ];
  logic [7:0] refm [MSZ];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dat_i = mem[bus.mem_adr];

  always @(posedge clk)
    if (bus.mem_en && bus.mem_we)
      mem[bus.mem_adr] <= bus.mem_dat_o;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request-level model: bytes, legality and big-endian packing.
  task automatic model(input bit we, input bit [1:0] size,
                       input bit [31:0] adr, input bit [31:0] wd,
                       output bit err, output bit [31:0] rd,
                       output int n);
    n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 :
         (size == 2'd2) ? 4 : 0;
    rd = 32'h0;
    err = (n == 0) || (adr % n != 0) || (adr >= MSZ);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (we)
          refm[adr + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
        else
          rd = rd * 256 + {24'h0, refm[adr + i]};
      end
    end
  endtask

  task automatic drive(input bit we, input bit [1:0] size,
                       input bit [31:0] adr, input bit [31:0] wd);
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_adr   = adr;
    bus.req_wdata = wd;
  endtask

  task automatic do_req(input bit we, input bit [1:0] size,
                        input bit [31:0] adr, input bit [31:0] wd);
    bit        eerr;
    bit [31:0] erd;
    int        n;
    int        lat;
    int        nb;
    bit        got;
    model(we, size, adr, wd, eerr, erd, n);
    @(negedge clk);
    drive(we, size, adr, wd);
    bus.req_valid = 1'b1;
    check("ready_before", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    nb  = 0;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        check("beat_adr", {18'h0, bus.mem_adr},
              (adr + nb) & (MSZ - 1));
        check("beat_we", {31'h0, bus.mem_we}, {31'h0, we});
        nb++;
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("rsp_seen", {31'h0, got}, 32'h1);
    check("latency", lat, eerr ? 1 : n + 1);
    check("beats", nb, eerr ? 0 : n);
    check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, eerr});
    check("rsp_rdata", bus.rsp_rdata, erd);
    @(negedge clk);
    check("pulse_len", {31'h0, bus.rsp_valid}, 32'h0);
    check("ready_after", {31'h0, bus.req_ready}, 32'h1);
    if (we && !eerr)
      for (int i = 0; i < n; i++)
        check("mem_byte", {24'h0, mem[adr + i]},
              {24'h0, refm[adr + i]});
  endtask

  bit         b_we  [3];
  bit [31:0]  b_adr [3];
  bit [31:0]  b_wd  [3];
  bit         b_err [3];
  bit [31:0]  b_rd  [3];
  int         rdy_c [$];

  initial begin
    bit [7:0]  v;
    bit        e;
    bit [31:0] r;
    int        n;
    int        idx;
    int        ri;
    bit        acc;
    bit        seen;
    bit [1:0]  sz;
    bit [31:0] a;
    int        mode;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < MSZ; i++) begin
      v = 8'($urandom);
      mem[i] <= v;
      refm[i] = v;
    end
    repeat (2) @(negedge clk);

    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mem_adr", {18'h0, bus.mem_adr}, 32'h0);
    check("rst_mem_dat", {24'h0, bus.mem_dat_o}, 32'h0);
    rst = 1'b0;

    do_req(1'b1, 2'd2, 32'h0100, 32'h11223344);
    check("w_b0", {24'h0, mem[16'h100]}, 32'h11);
    check("w_b1", {24'h0, mem[16'h101]}, 32'h22);
    check("w_b2", {24'h0, mem[16'h102]}, 32'h33);
    check("w_b3", {24'h0, mem[16'h103]}, 32'h44);
    do_req(1'b0, 2'd2, 32'h0100, 32'h0);
    check("w_load", bus.rsp_rdata, 32'h11223344);

    do_req(1'b1, 2'd1, 32'h0202, 32'h0000BEEF);
    check("h_b0", {24'h0, mem[16'h202]}, 32'hBE);
    check("h_b1", {24'h0, mem[16'h203]}, 32'hEF);
    do_req(1'b0, 2'd0, 32'h0203, 32'h0);
    check("b_load", bus.rsp_rdata, 32'h000000EF);

    do_req(1'b0, 2'd2, 32'h0102, 32'h0);
    do_req(1'b1, 2'd1, 32'h0001, 32'hFFFF);
    do_req(1'b0, 2'd3, 32'h0100, 32'h0);
    do_req(1'b1, 2'd2, 32'h00004000, 32'hCAFEF00D);

    do_req(1'b0, 2'd2, 32'h3FFC, 32'h0);

    b_we[0] = 1'b1; b_adr[0] = 32'h0400; b_wd[0] = 32'hA5B6C7D8;
    b_we[1] = 1'b0; b_adr[1] = 32'h0400; b_wd[1] = 32'h0;
    b_we[2] = 1'b0; b_adr[2] = 32'h0104; b_wd[2] = 32'h0;
    for (int k = 0; k < 3; k++)
      model(b_we[k], 2'd2, b_adr[k], b_wd[k], b_err[k], b_rd[k], n);
    @(negedge clk);
    idx = 0;
    ri  = 0;
    drive(b_we[0], 2'd2, b_adr[0], b_wd[0]);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 40 && ri < 3; c++) begin
      if (bus.rsp_valid) begin
        check("b2b_err", {31'h0, bus.rsp_err}, {31'h0, b_err[ri]});
        check("b2b_rdata", bus.rsp_rdata, b_rd[ri]);
        ri++;
      end
      acc = bus.req_ready;
      if (acc) rdy_c.push_back(c);
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) drive(b_we[idx], 2'd2, b_adr[idx], b_wd[idx]);
        else bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b_rsp_count", ri, 3);
    check("b2b_ready_count", rdy_c.size(), 3);
    if (rdy_c.size() == 3) begin
      check("b2b_gap0", rdy_c[1] - rdy_c[0], 6);
      check("b2b_gap1", rdy_c[2] - rdy_c[1], 6);
    end

    for (int i = 0; i < 4; i++) begin
      mem[16'h300 + i] <= 8'hA0 + 8'(i);
      refm[16'h300 + i] = 8'hA0 + 8'(i);
    end
    @(negedge clk);
    drive(1'b1, 2'd2, 32'h0300, 32'h55667788);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_beat0", {31'h0, bus.mem_en}, 32'h1);
    @(negedge clk);
    refm[16'h300] = 8'h55;
    rst = 1'b1;
    #1;
    check("rst_mid_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_mid_we", {31'h0, bus.mem_we}, 32'h0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("rst_mid_no_rsp", {31'h0, seen}, 32'h0);
    check("rst_mid_ready", {31'h0, bus.req_ready}, 32'h1);
    for (int i = 0; i < 4; i++)
      check("rst_mid_mem", {24'h0, mem[16'h300 + i]},
            {24'h0, refm[16'h300 + i]});

    for (int t = 0; t < 60; t++) begin
      sz   = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a    = $urandom_range(0, MSZ - 1);
      if (sz == 2'd1) a = a & ~32'h1;
      else if (sz != 2'd0) a = a & ~32'h3;
      if (mode == 0) a = a | 32'h1;
      else if (mode == 1) a = a + MSZ * $urandom_range(1, 1000);
      do_req(1'($urandom_range(0, 1)), sz, a, $urandom);
    end

    model(1'b0, 2'd0, 32'h0, 32'h0, e, r, n);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
